// File: rtl/sram_like_arb.sv
// sram_like_arb
//   Shares one sram-like memory port between the instruction-fetch requester
//   (inst_*) and the load/store requester (data_*). Accepted transactions are
//   tagged in an ordering FIFO (0 = inst, 1 = data) so in-order responses from
//   memory are steered back to the requester that issued them.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   inst_*/data_* req,wr,size,...   requester address phase (held until addr_ok)
//   inst_*/data_* addr_ok           address phase accepted for that requester
//   inst_*/data_* data_ok, rdata    response for that requester, rdata broadcast
//   mem_* req,wr,size,...           downstream address phase
//   mem_addr_ok, mem_data_ok, mem_rdata   downstream handshake / read data
//   err_unexp                       sticky: response arrived with no id queued
//
// Build option
//   ARB_RR_EN   defined: round-robin on IDLE conflicts; undefined: data wins.
//
// State table
//   ST_IDLE | no pending downstream request, winner chosen each cycle
//   ST_HOLD | request issued but not accepted; grant locked to own_q
module sram_like_arb #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                err_unexp
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              own_q, own_d;
  logic              fifo_q [MAX_OUTSTANDING];
  logic              fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
`ifdef ARB_RR_EN
  // Requester holding priority on the next conflict; always the one not
  // granted by the most recent push.
  logic              rr_ptr_q, rr_ptr_d;
`endif

  logic full, empty, conflict_pick, sel, sel_req, push, pop, head;

  always_comb begin
    full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    empty = (count_q == '0);

`ifdef ARB_RR_EN
    conflict_pick = rr_ptr_q;
`else
    conflict_pick = 1'b1;
`endif

    if (state_q == ST_HOLD)
      sel = own_q;
    else if (inst_req && data_req)
      sel = conflict_pick;
    else
      sel = data_req;

    sel_req = sel ? data_req : inst_req;

    mem_req   = sel_req & ~full & ~reset;
    mem_wr    = sel ? data_wr    : inst_wr;
    mem_size  = sel ? data_size  : inst_size;
    mem_wstrb = sel ? data_wstrb : inst_wstrb;
    mem_addr  = sel ? data_addr  : inst_addr;
    mem_wdata = sel ? data_wdata : inst_wdata;

    push         = mem_req & mem_addr_ok;
    inst_addr_ok = push & ~sel;
    data_addr_ok = push &  sel;

    head         = fifo_q[rd_ptr_q];
    pop          = mem_data_ok & ~empty & ~reset;
    inst_data_ok = pop & ~head;
    data_data_ok = pop &  head;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    err_unexp    = err_q;
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_d = ST_HOLD;
          own_d   = sel;
        end
      end
      ST_HOLD: begin
        // A dropped request is a requester protocol violation; release the
        // grant without queuing anything.
        if (!sel_req || push)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    fifo_d = fifo_q;
    if (push)
      fifo_d[wr_ptr_q] = sel;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    err_d = err_q | (mem_data_ok & empty);

`ifdef ARB_RR_EN
    rr_ptr_d = push ? ~sel : rr_ptr_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      own_q    <= 1'b0;
      fifo_q   <= '{default: 1'b0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
`ifdef ARB_RR_EN
      rr_ptr_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
`ifdef ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule
